// File: rtl/dmem_store_buffer_if.sv
// dmem_store_buffer_if: memory-stage bus between the core (master) and the
// data-memory store buffer (slave).
//   MemWriteM/MemReadM  : store / load request this cycle
//   ALUResultM          : byte address
//   WriteDataM          : right-aligned store data
//   MemControlM         : funct3 access size / signedness
//   ReadDataM           : extended load data (0 when no load)
//   StallM              : core must hold the M stage
//   MisalignM           : access misaligned and suppressed
//   SbEmpty             : store buffer holds no entries
interface dmem_store_buffer_if;
    logic        MemWriteM;
    logic        MemReadM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  MemControlM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        SbEmpty;

    modport master (
        output MemWriteM, MemReadM, ALUResultM, WriteDataM, MemControlM,
        input  ReadDataM, StallM, MisalignM, SbEmpty
    );

    modport slave (
        input  MemWriteM, MemReadM, ALUResultM, WriteDataM, MemControlM,
        output ReadDataM, StallM, MisalignM, SbEmpty
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: data-memory stage with a store buffer in front of a
// single-port word RAM. Stores are queued and retired by read-modify-write;
// loads read the RAM combinationally and are sign/zero extended.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset
//   bus    : dmem_store_buffer_if.slave (request in, load data/status out)
// Build option DMEM_SB_FWD_EN: when defined, loads merge younger buffered
// bytes and never stall; otherwise an overlapping load stalls until drained.
module dmem_store_buffer #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned SB_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    dmem_store_buffer_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned PW = $clog2(SB_DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [31:0]   r_ram     [DEPTH_WORDS];
    logic [AW-1:0] r_sb_idx  [SB_DEPTH];
    logic [3:0]    r_sb_mask [SB_DEPTH];
    logic [31:0]   r_sb_data [SB_DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;
    logic [1:0]    r_state;
    logic [31:0]   r_rd_word;

    logic [1:0]    w_state_nxt;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic          w_is_b, w_is_h, w_is_w, w_misalign;
    logic          w_st_req, w_ld_req, w_full, w_ld_stall, w_ld_ok;
    logic          w_free, w_enq, w_deq;
    logic [CW-1:0] w_count_nxt;
    logic [3:0]    w_mask;
    logic [31:0]   w_st_data;
    logic [31:0]   w_ram_word, w_fwd_word, w_lane, w_ext, w_wr_word;
    logic          w_overlap;
    logic [PW-1:0] w_slot;
    logic          w_unused_addr;

    assign w_idx         = bus.ALUResultM[AW+1:2];
    assign w_off         = bus.ALUResultM[1:0];
    assign w_unused_addr = ^bus.ALUResultM[31:AW+2];

    // Access size decode; unlisted funct3 codes behave as word accesses
    assign w_is_b = (bus.MemControlM == 3'b000) || (bus.MemControlM == 3'b100);
    assign w_is_h = (bus.MemControlM == 3'b001) || (bus.MemControlM == 3'b101);
    assign w_is_w = !(w_is_b || w_is_h);

    assign w_misalign = (bus.MemWriteM || bus.MemReadM) &&
                        ((w_is_h && w_off[0]) || (w_is_w && (w_off != 2'b00)));

    assign w_st_req = bus.MemWriteM && !w_misalign;
    assign w_ld_req = !bus.MemWriteM && bus.MemReadM && !w_misalign;
    assign w_full   = (r_count == CW'(SB_DEPTH));

    // Byte mask and lane-replicated data; the mask selects the live lanes
    always_comb begin
        w_mask    = 4'hF;
        w_st_data = bus.WriteDataM;
        if (w_is_b) begin
            w_mask    = 4'b0001 << w_off;
            w_st_data = {4{bus.WriteDataM[7:0]}};
        end else if (w_is_h) begin
            w_mask    = 4'b0011 << w_off;
            w_st_data = {2{bus.WriteDataM[15:0]}};
        end
    end

    // Walk valid entries oldest to newest so the newest byte wins
    assign w_ram_word = r_ram[w_idx];
    always_comb begin
        w_fwd_word = w_ram_word;
        w_overlap  = 1'b0;
        w_slot     = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            w_slot = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_sb_idx[w_slot] == w_idx)) begin
                if ((r_sb_mask[w_slot] & w_mask) != 4'h0) w_overlap = 1'b1;
                for (int unsigned b = 0; b < 4; b++) begin
                    if (r_sb_mask[w_slot][b]) w_fwd_word[8*b +: 8] = r_sb_data[w_slot][8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_SB_FWD_EN
    logic w_unused_fwd;
    assign w_unused_fwd = w_overlap ^ (^w_ram_word);
    assign w_ld_stall   = 1'b0;
    assign w_lane       = w_fwd_word >> {w_off, 3'b000};
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^w_fwd_word;
    assign w_ld_stall   = w_ld_req && w_overlap;
    assign w_lane       = w_ram_word >> {w_off, 3'b000};
`endif

    // An accepted load owns the RAM port; every other cycle is free for the drain
    assign w_ld_ok     = w_ld_req && !w_ld_stall;
    assign w_free      = !w_ld_ok;
    assign w_enq       = w_st_req && !w_full;
    assign w_deq       = (r_state == S_WRITE) && w_free;
    assign w_count_nxt = r_count + CW'(w_enq) - CW'(w_deq);

    always_comb begin
        w_ext = w_lane;
        if (w_is_b)      w_ext = bus.MemControlM[2] ? {24'h0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
        else if (w_is_h) w_ext = bus.MemControlM[2] ? {16'h0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
    end

    assign bus.ReadDataM = w_ld_ok ? w_ext : 32'h0;
    assign bus.StallM    = (w_st_req && w_full) || w_ld_stall;
    assign bus.MisalignM = w_misalign;
    assign bus.SbEmpty   = (r_count == '0);

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Drain FSM next state; READ/WRITE hold on cycles a load owns the port
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if ((r_count != '0) || w_enq) w_state_nxt = S_READ;
            S_READ:  if (w_free) w_state_nxt = S_WRITE;
            S_WRITE: if (w_free) w_state_nxt = (w_count_nxt != '0) ? S_READ : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + PW'(1);
            if (w_deq) r_head <= r_head + PW'(1);
            r_count <= w_count_nxt;
        end
    end

    // Entry storage and the drain's latched RAM word
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_sb_idx[r_tail]  <= w_idx;
            r_sb_mask[r_tail] <= w_mask;
            r_sb_data[r_tail] <= w_st_data;
        end
        if ((r_state == S_READ) && w_free) r_rd_word <= r_ram[r_sb_idx[r_head]];
    end

    always_comb begin
        w_wr_word = r_rd_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (r_sb_mask[r_head][b]) w_wr_word[8*b +: 8] = r_sb_data[r_head][8*b +: 8];
        end
    end

    // RAM write port; reset suppresses an in-flight retirement
    always_ff @(posedge clk) begin
        if (!reset && w_deq) r_ram[r_sb_idx[r_head]] <= w_wr_word;
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed self-checking bench for dmem_store_buffer.
module tb_dmem_store_buffer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_store_buffer_if bus_if ();
    dmem_store_buffer dut (.clk(clk), .reset(reset), .bus(bus_if));

`ifdef DMEM_SB_FWD_EN
    localparam int WSTALL = 0;
`else
    localparam int WSTALL = 2;
`endif

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] c);
        bus_if.MemWriteM   = w;
        bus_if.MemReadM    = r;
        bus_if.ALUResultM  = a;
        bus_if.WriteDataM  = d;
        bus_if.MemControlM = c;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
    endtask

    task automatic wait_empty(input int bound, output bit ok);
        int n = 0;
        while (!bus_if.SbEmpty && n < bound) begin
            cyc();
            n++;
        end
        ok = bus_if.SbEmpty;
    endtask

    task automatic wait_nostall(input int bound, output int n);
        n = 0;
        while (bus_if.StallM && n < bound) begin
            cyc();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if (bus_if.SbEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus_if.SbEmpty); end
        checks++;
        if (bus_if.StallM !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus_if.StallM); end
        checks++;
        if (bus_if.ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus_if.ReadDataM); end
    endtask

    task automatic test_word();
        int n;
        bit ok;
        drive(1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 3'b010);
        checks++;
        if (bus_if.StallM !== 1'b0) begin errors++; $display("FAIL sw_stall got %b want 0", bus_if.StallM); end
        cyc();
        drive(1'b0, 1'b1, 32'h100, 32'h0, 3'b010);
        wait_nostall(10, n);
        checks++;
        if (n != WSTALL) begin errors++; $display("FAIL lw_stall_cycles got %0d want %0d", n, WSTALL); end
        checks++;
        if (bus_if.ReadDataM !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_first got %h want deadbeef", bus_if.ReadDataM); end
        cyc();
        idle();
        wait_empty(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL word_drain got busy want empty"); end
        drive(1'b0, 1'b1, 32'h100, 32'h0, 3'b010);
        checks++;
        if (bus_if.ReadDataM !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_ram got %h want deadbeef", bus_if.ReadDataM); end
        cyc();
    endtask

    task automatic test_byte();
        int n;
        bit ok;
        drive(1'b1, 1'b0, 32'h101, 32'h00000080, 3'b000);
        cyc();
        drive(1'b0, 1'b1, 32'h101, 32'h0, 3'b000);
        wait_nostall(10, n);
        checks++;
        if (bus_if.ReadDataM !== 32'hFFFFFF80) begin errors++; $display("FAIL lb got %h want ffffff80", bus_if.ReadDataM); end
        cyc();
        drive(1'b0, 1'b1, 32'h101, 32'h0, 3'b100);
        wait_nostall(10, n);
        checks++;
        if (bus_if.ReadDataM !== 32'h00000080) begin errors++; $display("FAIL lbu got %h want 00000080", bus_if.ReadDataM); end
        cyc();
        drive(1'b0, 1'b1, 32'h100, 32'h0, 3'b010);
        wait_nostall(10, n);
        checks++;
        if (bus_if.ReadDataM !== 32'hDEAD80EF) begin errors++; $display("FAIL lw_merge got %h want dead80ef", bus_if.ReadDataM); end
        cyc();
        idle();
        wait_empty(20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL byte_drain got busy want empty"); end
    endtask

    task automatic test_fill();
        int exp_cnt [6] = '{1, 2, 2, 3, 3, 4};
        bit ok;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, 32'h200 + 32'(4*k), 32'hA0000000 + 32'(k), 3'b010);
            checks++;
            if (bus_if.StallM !== 1'b0) begin errors++; $display("FAIL fill_stall%0d got %b want 0", k, bus_if.StallM); end
            cyc();
            checks++;
            if (dut.r_count !== 3'(exp_cnt[k])) begin errors++; $display("FAIL fill_count%0d got %0d want %0d", k, dut.r_count, exp_cnt[k]); end
        end
        drive(1'b1, 1'b0, 32'h218, 32'hA0000006, 3'b010);
        checks++;
        if (bus_if.StallM !== 1'b1) begin errors++; $display("FAIL fill_full_stall got %b want 1", bus_if.StallM); end
        cyc();
        checks++;
        if (dut.r_count !== 3'd3) begin errors++; $display("FAIL fill_after_stall got %0d want 3", dut.r_count); end
        drive(1'b1, 1'b0, 32'h218, 32'hA0000006, 3'b010);
        checks++;
        if (bus_if.StallM !== 1'b0) begin errors++; $display("FAIL fill_retry_stall got %b want 0", bus_if.StallM); end
        cyc();
        checks++;
        if (dut.r_count !== 3'd4) begin errors++; $display("FAIL fill_final_count got %0d want 4", dut.r_count); end
        idle();
        wait_empty(40, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fill_drain got busy want empty"); end
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (dut.r_ram[128 + k] !== 32'hA0000000 + 32'(k)) begin
                errors++;
                $display("FAIL fill_ram%0d got %h want %h", k, dut.r_ram[128 + k], 32'hA0000000 + 32'(k));
            end
        end
    endtask

    task automatic test_load_prio();
        bit ok;
        drive(1'b1, 1'b0, 32'h300, 32'h13579BDF, 3'b010);
        cyc();
        drive(1'b1, 1'b0, 32'h304, 32'h2468ACE0, 3'b010);
        cyc();
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b1, 32'h400, 32'h0, 3'b010);
            checks++;
            if (bus_if.StallM !== 1'b0) begin errors++; $display("FAIL prio_stall%0d got %b want 0", k, bus_if.StallM); end
            cyc();
            checks++;
            if (dut.r_count !== 3'd2) begin errors++; $display("FAIL prio_hold%0d got %0d want 2", k, dut.r_count); end
        end
        idle();
        cyc();
        checks++;
        if (dut.r_count !== 3'd1) begin errors++; $display("FAIL prio_resume got %0d want 1", dut.r_count); end
        wait_empty(20, ok);
        checks++;
        if (dut.r_ram[192] !== 32'h13579BDF || dut.r_ram[193] !== 32'h2468ACE0) begin
            errors++;
            $display("FAIL prio_ram got %h %h want 13579bdf 2468ace0", dut.r_ram[192], dut.r_ram[193]);
        end
    endtask

    task automatic test_misalign();
        drive(1'b0, 1'b1, 32'h103, 32'h0, 3'b001);
        checks++;
        if (bus_if.MisalignM !== 1'b1 || bus_if.ReadDataM !== 32'h0) begin
            errors++;
            $display("FAIL lh_misalign got mis=%b data=%h want mis=1 data=0", bus_if.MisalignM, bus_if.ReadDataM);
        end
        drive(1'b1, 1'b0, 32'h102, 32'h55, 3'b010);
        checks++;
        if (bus_if.MisalignM !== 1'b1 || bus_if.StallM !== 1'b0) begin
            errors++;
            $display("FAIL sw_misalign got mis=%b stall=%b want mis=1 stall=0", bus_if.MisalignM, bus_if.StallM);
        end
        cyc();
        checks++;
        if (dut.r_count !== 3'd0) begin errors++; $display("FAIL sw_misalign_count got %0d want 0", dut.r_count); end
        idle();
    endtask

    task automatic test_reset_mid();
        bit ok;
        drive(1'b1, 1'b0, 32'h504, 32'h11111111, 3'b010);
        cyc();
        idle();
        wait_empty(20, ok);
        drive(1'b1, 1'b0, 32'h500, 32'hAAAA0000, 3'b010); cyc();
        drive(1'b1, 1'b0, 32'h504, 32'hBBBB1111, 3'b010); cyc();
        drive(1'b1, 1'b0, 32'h508, 32'hCCCC2222, 3'b010); cyc();
        drive(1'b1, 1'b0, 32'h50C, 32'hDDDD3333, 3'b010); cyc();
        checks++;
        if (dut.r_count !== 3'd3 || dut.r_state !== 2'd2) begin
            errors++;
            $display("FAIL mid_setup got count=%0d state=%0d want 3 2", dut.r_count, dut.r_state);
        end
        reset = 1'b1;
        idle();
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if (bus_if.SbEmpty !== 1'b1 || bus_if.StallM !== 1'b0) begin
            errors++;
            $display("FAIL mid_flags got empty=%b stall=%b want 1 0", bus_if.SbEmpty, bus_if.StallM);
        end
        checks++;
        if (dut.r_ram[321] !== 32'h11111111) begin errors++; $display("FAIL mid_target got %h want 11111111", dut.r_ram[321]); end
        checks++;
        if (dut.r_ram[320] !== 32'hAAAA0000) begin errors++; $display("FAIL mid_retired got %h want aaaa0000", dut.r_ram[320]); end
        drive(1'b0, 1'b1, 32'h504, 32'h0, 3'b010);
        checks++;
        if (bus_if.ReadDataM !== 32'h11111111 || bus_if.StallM !== 1'b0) begin
            errors++;
            $display("FAIL mid_load got %h stall=%b want 11111111 0", bus_if.ReadDataM, bus_if.StallM);
        end
        cyc();
        idle();
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_fill();
        test_load_prio();
        test_misalign();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
